// File: rtl/par2ser_shift_pkg.sv
// rtl/par2ser_shift_pkg.sv - shared types and constants for the parallel-to-serial shifter
package par2ser_shift_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Idle level of the serial line, shared with the detector benches.
    localparam logic DEF_FILL_BIT = 1'b0;

    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/par2ser_shift.sv
// rtl/par2ser_shift.sv - parallel word in via valid/ready, one bit per clock out, gap-free
module par2ser_shift
    import par2ser_shift_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic FILL_BIT  = DEF_FILL_BIT
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    output logic             din_rdy,
    output logic             dout,
    output logic             dout_vld,
    output logic             frame_end,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   sreg;
    logic [CNT_W-1:0]   cnt;
    logic               last_bit;
    logic               accept;
    logic               first_bit;
    logic               next_bit;
    logic [WIDTH-1:0]   load_val;
    logic [WIDTH-1:0]   adv_val;

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign din_rdy  = (state == ST_IDLE) | ((state == ST_SHIFT) & last_bit);
    // An unknown din_vld leaves accept unknown, which the if() below treats as no accept.
    assign accept   = din_vld & din_rdy;
    assign busy     = (state == ST_SHIFT);

    // The register holds the bits still to be sent, already advanced past the bit on dout.
    assign first_bit = MSB_FIRST ? din[WIDTH-1] : din[0];
    assign load_val  = MSB_FIRST ? {din[WIDTH-2:0], 1'b0} : {1'b0, din[WIDTH-1:1]};
    assign next_bit  = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    assign adv_val   = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= ST_IDLE;
            sreg      <= '0;
            cnt       <= '0;
            dout      <= FILL_BIT;
            dout_vld  <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            if (accept) begin
                state     <= ST_SHIFT;
                sreg      <= load_val;
                cnt       <= '0;
                dout      <= first_bit;
                dout_vld  <= 1'b1;
                frame_end <= 1'b0;
            end else if ((state == ST_SHIFT) && !last_bit) begin
                sreg      <= adv_val;
                cnt       <= cnt + 1'b1;
                dout      <= next_bit;
                frame_end <= (cnt == CNT_W'(WIDTH - 2));
            end else begin
                state     <= ST_IDLE;
                cnt       <= '0;
                dout      <= FILL_BIT;
                dout_vld  <= 1'b0;
                frame_end <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_par2ser_shift.sv
// tb/tb_par2ser_shift.sv - randomized and directed bench for par2ser_shift with a bit-queue model
module tb_par2ser_shift;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_vld = 1'b0;

    logic din_rdy_m, dout_m, dout_vld_m, frame_end_m, busy_m;
    logic din_rdy_l, dout_l, dout_vld_l, frame_end_l, busy_l;

    int checks = 0;
    int failures = 0;

    par2ser_shift #(.WIDTH(8), .MSB_FIRST(1'b1), .FILL_BIT(1'b0)) dut_m (
        .clk(clk), .clr(clr), .din(din), .din_vld(din_vld), .din_rdy(din_rdy_m),
        .dout(dout_m), .dout_vld(dout_vld_m), .frame_end(frame_end_m), .busy(busy_m)
    );

    par2ser_shift #(.WIDTH(8), .MSB_FIRST(1'b0), .FILL_BIT(1'b0)) dut_l (
        .clk(clk), .clr(clr), .din(din), .din_vld(din_vld), .din_rdy(din_rdy_l),
        .dout(dout_l), .dout_vld(dout_vld_l), .frame_end(frame_end_l), .busy(busy_l)
    );

    always #5 clk = ~clk;

    // Model: queue of bits still owed on the line; head is the bit currently on dout.
    bit qm[$];
    bit ql[$];

    always @(posedge clk) begin
        if (clr) begin
            bit rdy;
            rdy = (qm.size() <= 1);
            if (qm.size() > 0) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if ((din_vld === 1'b1) && rdy) begin
                for (int i = 0; i < 8; i++) begin
                    qm.push_back(din[7-i]);
                    ql.push_back(din[i]);
                end
            end
        end
    end

    always @(negedge clr) begin
        qm.delete();
        ql.delete();
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of {dout, dout_vld, frame_end, busy, din_rdy} against the model.
    always @(negedge clk) begin
        logic [4:0] em, el;
        em = {(qm.size() > 0) ? qm[0] : 1'b0, qm.size() > 0, qm.size() == 1,
              qm.size() > 0, qm.size() <= 1};
        el = {(ql.size() > 0) ? ql[0] : 1'b0, ql.size() > 0, ql.size() == 1,
              ql.size() > 0, ql.size() <= 1};
        check("model_msb", {dout_m, dout_vld_m, frame_end_m, busy_m, din_rdy_m}, em);
        check("model_lsb", {dout_l, dout_vld_l, frame_end_l, busy_l, din_rdy_l}, el);
    end

    // Collected serial streams (first bit ends up most significant) and frame_end marks.
    logic [15:0] col_m, col_l, fe_m;
    int ncol;

    always @(negedge clk) begin
        if (dout_vld_m) begin
            col_m = {col_m[14:0], dout_m};
            fe_m  = {fe_m[14:0], frame_end_m};
            ncol++;
        end
        if (dout_vld_l)
            col_l = {col_l[14:0], dout_l};
    end

    task automatic clear_col();
        col_m = '0;
        col_l = '0;
        fe_m  = '0;
        ncol  = 0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] w, input bit keep);
        int n;
        n = 0;
        din = w;
        din_vld = 1'b1;
        while (!din_rdy_m && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            failures++;
            $display("FAIL send_timeout word=%0h", w);
        end
        @(negedge clk);
        if (!keep) din_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_m && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            failures++;
            $display("FAIL idle_timeout busy=%0b", busy_m);
        end
        @(negedge clk);
    endtask

    initial begin
        clear_col();
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        #1;
        check("reset_state", {dout_m, dout_vld_m, frame_end_m, busy_m, din_rdy_m}, 5'b00001);
        @(negedge clk);

        // Single word
        clear_col();
        send(8'b0111_0000, 1'b0);
        wait_idle();
        check("single_bits", col_m[7:0], 8'h70);
        check("single_count", ncol, 8);
        check("single_fe", fe_m[7:0], 8'h01);
        check("lsb_first_bits", col_l[7:0], 8'h0E);

        // Back-to-back
        clear_col();
        send(8'hA5, 1'b1);
        send(8'h3C, 1'b0);
        wait_idle();
        check("b2b_bits", col_m, 16'hA53C);
        check("b2b_count", ncol, 16);
        check("b2b_fe", fe_m, 16'h0101);

        // Hold while busy
        clear_col();
        send(8'h5A, 1'b0);
        @(negedge clk);
        send(8'hFF, 1'b0);
        wait_idle();
        check("hold_bits", col_m, 16'h5AFF);
        check("hold_count", ncol, 16);

        // Async reset mid-word
        clear_col();
        send(8'hC3, 1'b0);
        repeat (2) @(negedge clk);
        #2 clr = 1'b0;
        #1;
        check("async_drop", {dout_vld_m, frame_end_m, busy_m, dout_vld_l}, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clear_col();
        send(8'h81, 1'b0);
        wait_idle();
        check("after_reset_bits", col_m[7:0], 8'h81);
        check("after_reset_count", ncol, 8);

        // LSB-first instance carrying the 01110 pattern
        clear_col();
        send(8'b0000_1110, 1'b0);
        wait_idle();
        check("lsb_pattern", col_l[7:0], 8'b0111_0000);
        check("lsb_detect_window", col_l[7:3], 5'b01110);

        // Random traffic with occasional asynchronous resets
        for (int i = 0; i < 600; i++) begin
            din = 8'($urandom);
            din_vld = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                #2 clr = 1'b0;
                #2 clr = 1'b1;
            end
            @(negedge clk);
        end
        din_vld = 1'b0;
        repeat (12) @(negedge clk);
        check("final_idle", {dout_vld_m, busy_m, din_rdy_m}, 3'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/par2ser_shift.md
Name: par2ser_shift

Overview:
- Upstream feeder for the serial sequence detectors (01110 and similar).
- Accepts a parallel word through a valid/ready handshake and shifts it out one bit per clock.
- Output is a serial bit with a qualifying valid, so detectors and benches see deterministic, gap-free bit streams.
- Supports back-to-back words with zero bubble cycles.

Parameters:
- WIDTH, 8, parallel word width in bits (legal range 2..32).
- MSB_FIRST, 1, 1 = din[WIDTH-1] sent first; 0 = din[0] sent first.
- FILL_BIT, 1'b0, level driven on dout while dout_vld = 0.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous active-low reset.
- din  input  WIDTH  parallel word to serialise.
- din_vld  input  1  din is valid.
- din_rdy  output  1  block can accept a word this cycle. Combinational.
- dout  output  1  serial bit, registered.
- dout_vld  output  1  dout carries a payload bit, registered.
- frame_end  output  1  high with the last bit of each word, registered.
- busy  output  1  word in flight (state == SHIFT).

Behaviour:
- Clock and reset: one clock, clk. Reset clr is asynchronous, active-low. All flops clear immediately on clr = 0.
- Reset values: state = IDLE, shift register = 0, bit counter = 0, dout = FILL_BIT, dout_vld = 0, frame_end = 0. din_rdy = 1 once clr is released.
- States: IDLE, SHIFT (2 states, 1-bit encoding).
- Handshake: a word is accepted on a rising edge where din_vld & din_rdy. When din_vld = 1 and din_rdy = 0, the block ignores the word; upstream holds din and din_vld stable until accepted.
- din_rdy = (state == IDLE) | (state == SHIFT & bit counter == WIDTH-1).
- Latency: the first bit of an accepted word appears on dout in the cycle after acceptance. Each bit is held exactly 1 cycle, and the word occupies WIDTH consecutive cycles.
- IDLE:
  - accept → load shift register, counter = 0, dout = first bit, dout_vld = 1, go to SHIFT.
  - otherwise dout = FILL_BIT, dout_vld = 0.
- SHIFT:
  - Each cycle: shift register advances by one, counter += 1, dout = next bit.
  - At counter == WIDTH-1: frame_end = 1 in that cycle.
  - On the following edge: accept pending → reload, counter = 0, stay in SHIFT (no gap). No accept → go to IDLE, dout = FILL_BIT, dout_vld = 0.
- Counter: width $clog2(WIDTH). It never exceeds WIDTH-1; wrap to 0 occurs only on reload or exit.
- frame_end is asserted only together with dout_vld = 1.
- Reset mid-word: the word is discarded, no partial bits continue, and the next accepted word starts cleanly.
- din changing during SHIFT has no effect, because the data is captured at acceptance.
- X on din_vld while idle must not be propagated into the state. The next-state logic treats only din_vld == 1 as accept.

Decomposition:
- Shared package holds:
  - state encodings ST_IDLE = 1'b0, ST_SHIFT = 1'b1;
  - function/constant for counter width, clog2(WIDTH);
  - default FILL_BIT constant, shared with detector benches.
- Single module; no sub-module. Shift register, counter and FSM fit in one file (~150 lines).
- Optional bench-only wrapper: par2ser_shift feeding seq_detect_01110, with dout tied to the detector's data input, for end-to-end checks.

Test Plan:
- Reset: clr low for 3 cycles, then high → dout = 0, dout_vld = 0, frame_end = 0, busy = 0, din_rdy = 1.
- Single word, WIDTH = 8, MSB_FIRST = 1, din = 8'b0111_0000 accepted at cycle 0 → dout = 0,1,1,1,0,0,0,0 on cycles 1–8. dout_vld = 1 on cycles 1–8, frame_end only on cycle 8, dout_vld = 0 on cycle 9.
- Back-to-back: din = 8'hA5 then 8'h3C, din_vld held high → 16 contiguous valid bits 1010_0101_0011_1100. din_rdy is high on cycle 0 and cycle 8 only; frame_end is high on cycles 8 and 16.
- Hold while busy: din_vld = 1 with din = 8'hFF during cycles 2–7 of a word → not accepted until din_rdy = 1 at cycle 8; the current word's bits are unaffected.
- Async reset mid-word: clr pulsed low between edges at bit 3 → dout_vld drops immediately with no clock edge. Next word 8'h81 restarts from bit 0 → 1,0,0,0,0,0,0,1.
- MSB_FIRST = 0: din = 8'b0000_1110 → dout = 0,1,1,1,0,0,0,0. End-to-end with the detector, this stream must raise the detector's Z at the expected cycle.
